// File: rtl/bme280_pkg.sv
// Shared constants and state types for the BME280 measurement sequencer.
// Optional chip-ID check is enabled with BME280_SEQ_CHIP_ID_EN.
package bme280_pkg;

    localparam logic [7:0] REG_ID        = 8'hD0;
    localparam logic [7:0] REG_CTRL_HUM  = 8'hF2;
    localparam logic [7:0] REG_CTRL_MEAS = 8'hF4;
    localparam logic [7:0] REG_DATA      = 8'hF7;
    localparam logic [7:0] CHIP_ID       = 8'h60;

    typedef enum logic [2:0] {
        IDLE,
        CHK_ID,
        WR_HUM,
        WR_MEAS,
        MEAS_WAIT,
        RD_DATA,
        FINISH
    } state_t;

    typedef enum logic [1:0] {
        SUB_ISSUE,
        SUB_WAIT,
        SUB_CAPTURE
    } sub_t;

endpackage

// File: rtl/bme280_txn_timer.sv
// Loadable down-counter that stops at zero; drives a zero flag.
// Shared by the per-transaction wait and the measurement wait.
module bme280_txn_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/bme280_sequencer.sv
// BME280 one-shot measurement sequencer driving a byte-wide I2C master.
// Define BME280_SEQ_CHIP_ID_EN to read and check register 0xD0 first.
module bme280_sequencer
    import bme280_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR       = 7'h76,
    parameter int         TXN_CYCLES       = 128,
    parameter int         MEAS_WAIT_CYCLES = 1000000,
    parameter logic [2:0] OSRS_H           = 3'b001,
    parameter logic [2:0] OSRS_T           = 3'b001,
    parameter logic [2:0] OSRS_P           = 3'b001,
    parameter logic [1:0] MODE             = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        i2c_en,
    output logic [6:0]  i2c_slave_address,
    output logic        i2c_read_write,
    output logic [7:0]  i2c_register_address,
    output logic [7:0]  i2c_data_wr,
    input  logic [7:0]  i2c_data_rd,
    output logic [19:0] raw_press,
    output logic [19:0] raw_temp,
    output logic [15:0] raw_hum,
    output logic        chip_id_err
);

    localparam int MAXC = (TXN_CYCLES > MEAS_WAIT_CYCLES) ?
                          TXN_CYCLES : MEAS_WAIT_CYCLES;
    localparam int CW = $clog2(MAXC) + 1;

    state_t       state, state_n;
    sub_t         sub, sub_n;
    logic [2:0]   idx;
    logic [7:0]   rx [8];
    logic         t_load;
    logic [CW-1:0] t_val;
    logic         t_zero;
    logic         start_ok;
    logic         id_err;

    bme280_txn_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    // done is high on the first IDLE cycle, which also masks start there
    assign start_ok = (state == IDLE) && start && !done;
    assign busy = (state != IDLE);
    assign i2c_slave_address = SLAVE_ADDR;
    assign chip_id_err = id_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sub      <= SUB_ISSUE;
            idx      <= '0;
            done     <= 1'b0;
            raw_press <= '0;
            raw_temp <= '0;
            raw_hum  <= '0;
            for (int i = 0; i < 8; i++) rx[i] <= '0;
        end else begin
            state <= state_n;
            sub   <= sub_n;
            done  <= (state == FINISH);
            if (start_ok) idx <= '0;
            if (state == RD_DATA && sub == SUB_CAPTURE) begin
                rx[idx] <= i2c_data_rd;
                idx     <= idx + 3'd1;
            end
            if (state == FINISH && !id_err) begin
                raw_press <= {rx[0], rx[1], rx[2][7:4]};
                raw_temp  <= {rx[3], rx[4], rx[5][7:4]};
                raw_hum   <= {rx[6], rx[7]};
            end
        end
    end

`ifdef BME280_SEQ_CHIP_ID_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            id_err <= 1'b0;
        end else if (start_ok) begin
            id_err <= 1'b0;
        end else if (state == CHK_ID && sub == SUB_CAPTURE &&
                     i2c_data_rd != CHIP_ID) begin
            id_err <= 1'b1;
        end
    end
`else
    assign id_err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        sub_n   = sub;
        t_load  = 1'b0;
        t_val   = '0;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
`ifdef BME280_SEQ_CHIP_ID_EN
                    state_n = CHK_ID;
`else
                    state_n = WR_HUM;
`endif
                    sub_n = SUB_ISSUE;
                end
            end
            MEAS_WAIT: begin
                if (t_zero) begin
                    state_n = RD_DATA;
                    sub_n   = SUB_ISSUE;
                end
            end
            FINISH: state_n = IDLE;
            default: begin
                unique case (sub)
                    SUB_ISSUE: begin
                        sub_n  = SUB_WAIT;
                        t_load = 1'b1;
                        t_val  = CW'(TXN_CYCLES - 1);
                    end
                    SUB_WAIT: if (t_zero) sub_n = SUB_CAPTURE;
                    default: begin
                        sub_n = SUB_ISSUE;
                        unique case (state)
`ifdef BME280_SEQ_CHIP_ID_EN
                            CHK_ID: state_n = (i2c_data_rd == CHIP_ID) ?
                                              WR_HUM : FINISH;
`endif
                            WR_HUM: state_n = WR_MEAS;
                            WR_MEAS: begin
                                state_n = MEAS_WAIT;
                                t_load  = 1'b1;
                                t_val   = CW'(MEAS_WAIT_CYCLES - 1);
                            end
                            RD_DATA: if (idx == 3'd7) state_n = FINISH;
                            default: state_n = state;
                        endcase
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        i2c_en               = 1'b0;
        i2c_read_write       = 1'b0;
        i2c_register_address = '0;
        i2c_data_wr          = '0;
        unique case (state)
`ifdef BME280_SEQ_CHIP_ID_EN
            CHK_ID: begin
                i2c_en               = (sub == SUB_ISSUE);
                i2c_read_write       = 1'b1;
                i2c_register_address = REG_ID;
            end
`endif
            WR_HUM: begin
                i2c_en               = (sub == SUB_ISSUE);
                i2c_register_address = REG_CTRL_HUM;
                i2c_data_wr          = {5'b0, OSRS_H};
            end
            WR_MEAS: begin
                i2c_en               = (sub == SUB_ISSUE);
                i2c_register_address = REG_CTRL_MEAS;
                i2c_data_wr          = {OSRS_T, OSRS_P, MODE};
            end
            RD_DATA: begin
                i2c_en               = (sub == SUB_ISSUE);
                i2c_read_write       = 1'b1;
                i2c_register_address = REG_DATA + {5'b0, idx};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bme280_sequencer.sv
// Directed bench for bme280_sequencer with a register-map slave model.
// Expects the chip-ID read when built with BME280_SEQ_CHIP_ID_EN.
module tb_bme280_sequencer;

    localparam int TXN = 8;
    localparam int MW  = 10;
`ifdef BME280_SEQ_CHIP_ID_EN
    localparam int NID = 1;
`else
    localparam int NID = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, i2c_en, i2c_read_write, chip_id_err;
    logic [6:0]  i2c_slave_address;
    logic [7:0]  i2c_register_address, i2c_data_wr, i2c_data_rd;
    logic [19:0] raw_press, raw_temp;
    logic [15:0] raw_hum;

    logic [7:0]  mem [256];
    logic [16:0] exp_q [$];
    logic [56:0] res_q [$];
    int          en_cyc [$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          en_n = 0;
    int          done_n = 0;
    int          base;
    bit          prev_en = 1'b0;

    bme280_sequencer #(
        .TXN_CYCLES       (TXN),
        .MEAS_WAIT_CYCLES (MW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .busy                 (busy),
        .done                 (done),
        .i2c_en               (i2c_en),
        .i2c_slave_address    (i2c_slave_address),
        .i2c_read_write       (i2c_read_write),
        .i2c_register_address (i2c_register_address),
        .i2c_data_wr          (i2c_data_wr),
        .i2c_data_rd          (i2c_data_rd),
        .raw_press            (raw_press),
        .raw_temp             (raw_temp),
        .raw_hum              (raw_hum),
        .chip_id_err          (chip_id_err)
    );

    always #5 clk = ~clk;

    assign i2c_data_rd = mem[i2c_register_address];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // transaction and result monitor, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (i2c_en === 1'b1) begin
            check("en_back_to_back", prev_en, 0);
            en_n++;
            en_cyc.push_back(cyc);
            if (exp_q.size() == 0)
                check("unexpected_en", 1, 0);
            else
                check("txn", {i2c_read_write, i2c_register_address,
                              i2c_read_write ? 8'h00 : i2c_data_wr},
                      exp_q.pop_front());
        end
        prev_en = (i2c_en === 1'b1);
        if (done === 1'b1) begin
            done_n++;
            if (res_q.size() == 0)
                check("unexpected_done", 1, 0);
            else
                check("result", {raw_press, raw_temp, raw_hum, chip_id_err},
                      res_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_setup(input logic [63:0] d);
        for (int i = 0; i < 8; i++) mem[8'hF7 + i] = d[63 - 8*i -: 8];
        mem[8'hD0] = 8'h60;
        if (NID == 1) exp_q.push_back({1'b1, 8'hD0, 8'h00});
        exp_q.push_back({1'b0, 8'hF2, 8'h01});
        exp_q.push_back({1'b0, 8'hF4, 8'h25});
        for (int i = 0; i < 8; i++)
            exp_q.push_back({1'b1, 8'(8'hF7 + i), 8'h00});
        res_q.push_back({d[63:44], d[39:20], d[15:0], 1'b0});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input bit poke);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            start = poke && (busy === 1'b1) && (n % 7 == 3);
            tick(1);
            n++;
        end
        start = 1'b0;
        if (n >= 2000) check("done_timeout", 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", i2c_en, 0);
        check("rst_rw", i2c_read_write, 0);
        check("rst_reg", i2c_register_address, 0);
        check("rst_wdata", i2c_data_wr, 0);
        check("rst_press", raw_press, 0);
        check("rst_temp", raw_temp, 0);
        check("rst_hum", raw_hum, 0);
        check("rst_id_err", chip_id_err, 0);
        check("slave_addr", i2c_slave_address, 7'h76);
        rst = 1'b0;
        tick(2);

        // run 1: repeated start while busy, then start on the done cycle
        run_setup(64'h512A_C07E_3390_661F);
        base = en_n;
        pulse_start();
        check("busy_after_start", busy, 1);
        wait_done(1'b1);
        check("press1", raw_press, 20'h512AC);
        check("temp1", raw_temp, 20'h7E339);
        check("hum1", raw_hum, 16'h661F);
        pulse_start();
        tick(20);
        check("start_on_done_ignored", busy, 0);
        check("en_count1", en_n - base, 10 + NID);
        check("done_count1", done_n, 1);
        check("txn_drained1", exp_q.size(), 0);
        check("meas_gap", en_cyc[base + NID + 2] - en_cyc[base + NID + 1],
              MW + TXN + 2);
        check("read_gap", en_cyc[base + NID + 3] - en_cyc[base + NID + 2],
              TXN + 2);

        // run 2: low nibbles of b2/b5 must be dropped
        run_setup(64'hFFFF_F000_000F_8001);
        pulse_start();
        wait_done(1'b0);
        check("press2", raw_press, 20'hFFFFF);
        check("temp2", raw_temp, 20'h00000);
        check("hum2", raw_hum, 16'h8001);
        tick(2);

        // reset during the 4th data read
        run_setup(64'h0102_0304_0506_0708);
        base = en_n;
        pulse_start();
        for (int n = 0; n < 2000 && en_n < base + NID + 6; n++) tick(1);
        check("reached_4th_read", en_n - base, NID + 6);
        tick(3);
        rst = 1'b1;
        tick(1);
        check("abort_en", i2c_en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_press", raw_press, 0);
        rst = 1'b0;
        exp_q.delete();
        res_q.delete();
        base = en_n;
        tick(30);
        check("no_en_after_rst", en_n - base, 0);

        run_setup(64'h512A_C07E_3390_661F);
        base = en_n;
        pulse_start();
        wait_done(1'b0);
        check("press3", raw_press, 20'h512AC);
        check("temp3", raw_temp, 20'h7E339);
        check("hum3", raw_hum, 16'h661F);
        tick(5);
        check("en_count3", en_n - base, 10 + NID);
        check("done_count3", done_n, 3);

`ifdef BME280_SEQ_CHIP_ID_EN
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        mem[8'hD0] = 8'h58;
        exp_q.push_back({1'b1, 8'hD0, 8'h00});
        res_q.push_back({20'h0, 20'h0, 16'h0, 1'b1});
        base = en_n;
        pulse_start();
        wait_done(1'b0);
        tick(20);
        check("id_err_set", chip_id_err, 1);
        check("id_err_en_count", en_n - base, 1);
        check("id_err_press", raw_press, 0);
        run_setup(64'h1122_3344_5566_7788);
        pulse_start();
        tick(2);
        check("id_err_cleared", chip_id_err, 0);
        wait_done(1'b0);
        tick(2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
